fp_addsub_pipe: RTL
===================

// Module: fp_addsub_pipe
// PURPOSE
//  Parametrised, fully pipelined IEEE-style floating-point adder/subtractor.
//  Accepts one operation per cycle and uses valid/ready backpressure on both sides.
//  Generalises the BF16 adder to any EXP_W/MAN_W format (BF16, FP16, FP32), adds
//  subtract mode, round-to-nearest-even, NaN/Inf handling, exception flags and an
//  opaque tag. Sits between operand FIFOs and the vector accumulate datapath.
// PARAMETERS
//  EXP_W  8  exponent field width (>=4); bias = 2**(EXP_W-1)-1
//  MAN_W  7  stored fraction width (>=3); the hidden bit is implicit
//  TAG_W  4  width of the user tag carried alongside each operation (>=1)
// PORTS  (W = 1+EXP_W+MAN_W)
//  clk         in   1      clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  in_valid    in   1      operation offered
//  in_ready    out  1      block accepts when in_valid & in_ready
//  in_a        in   W      operand A {sign,exp,frac}
//  in_b        in   W      operand B
//  in_sub      in   1      1: compute A-B, 0: compute A+B
//  in_tag      in   TAG_W  returned unchanged with the result
//  out_valid   out  1      result available
//  out_ready   in   1      consumer takes the result when out_valid & out_ready
//  out_result  out  W      rounded result
//  out_tag     out  TAG_W  tag of this result
//  out_flags   out  4      {NV invalid, OF overflow, UF underflow, NX inexact}
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-low (rst_n). All stage valid
//   bits clear. out_valid=0, out_result=0, out_tag=0, out_flags=0, in_ready=1.
//   Reset mid-operation discards every in-flight operation.
//  Pipeline: 3 register stages. S1 = unpack/swap/align, S2 = add/sub, S3 = normalise/
//   round/pack. S3 is the output register. Latency is 3 cycles from accept to
//   out_valid when unstalled. Throughput is 1 op per cycle.
//  Flow control: a stage loads when its downstream is empty or advancing in the same
//   cycle. in_ready = !s1_v | s1_adv. in_ready must not depend combinationally on
//   in_valid. Results leave in order. Outputs hold stable while out_valid & !out_ready.
//   If out_ready stays low, the block holds 3 ops. in_ready then drops, and it rises
//   again in the same cycle that out_ready is seen high.
//  Unpack: eff_sign_b = b.sign ^ in_sub. exp==0 operands are treated as signed zero
//   (DAZ). exp==all-ones is Inf (frac 0) or NaN (frac !=0). sNaN = frac MSB 0.
//  Align: the larger magnitude is selected by {exp,frac}. The smaller mantissa
//   {1,frac} is shifted right by the exponent difference into MAN_W+4 bits:
//   hidden + frac + G + R + S. S is the OR of all bits shifted beyond R. A difference
//   >= MAN_W+3 leaves only S (=1 if the operand is nonzero).
//  Add: the result is MAN_W+5 bits wide, with a carry bit. On subtract the larger
//   magnitude minus the smaller is never negative. Result sign = sign of the larger.
//  Normalise: on carry, shift right 1 and OR the dropped bit into S, exp+1. Otherwise
//   shift left by the leading-zero count, exp-lzc.
//  Round: RNE. Increment when G & (R|S|lsb). NX = G|R|S. A mantissa carry-out bumps
//   the exponent.
//  Overflow: exp >= all-ones gives signed Inf with OF|NX.
//  Underflow: exp <= 0 after normalise gives signed zero (FTZ) with UF|NX.
//  Exact zero from cancellation is +0. (-0)+(-0) = -0. (+0)+(-0) = +0.
//  Specials (override the arithmetic):
//   - any NaN input -> canonical qNaN {0, all-ones, 1, 0...}. NV only if an input is sNaN.
//   - Inf - Inf (effective) -> qNaN with NV.
//   - Inf op finite -> that Inf, flags 0.
//   - Inf + Inf (same sign) -> Inf.
// TESTING  (BF16 defaults unless noted)
//  0x3F80 + 0x3F80 -> 0x4000, flags 0, latency 3 cycles, tag echoed.
//  0x3F80 sub 0x3F80 -> 0x0000 (+0). 0x8000 + 0x8000 -> 0x8000.
//  RNE ties: 0x3F80 + 0x3B80 -> 0x3F80, NX. 0x3F81 + 0x3B80 -> 0x3F82, NX.
//  0x7F7F + 0x7F7F -> 0x7F80, OF|NX. 0x7F80 + 0xFF80 -> 0x7FC0, NV.
//   0x7F81 + 0x3F80 -> 0x7FC0, NV.
//  Stream 6 ops back-to-back with out_ready low for 5 cycles -> in_ready drops after
//   3 accepts, no loss, tags in order. Assert rst_n low mid-stream -> out_valid=0 next cycle.
//  EXP_W=8, MAN_W=23: 0x3F800000 + 0x3F800000 -> 0x40000000. Random compare vs reference model.

Source files
------------

// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor (parametrised format, RNE,
// DAZ/FTZ, NaN/Inf handling, exception flags) with valid/ready flow control.
module fp_addsub_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 7,
  parameter int unsigned TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [EXP_W+MAN_W:0]       in_a,
  input  logic [EXP_W+MAN_W:0]       in_b,
  input  logic                       in_sub,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+MAN_W:0]       out_result,
  output logic [TAG_W-1:0]           out_tag,
  output logic [3:0]                 out_flags
);

  localparam int unsigned W   = 1 + EXP_W + MAN_W;
  localparam int unsigned MW  = MAN_W + 4;          // hidden + frac + G + R + S
  localparam int unsigned SW  = MAN_W + 5;          // sum with carry
  localparam int unsigned EW  = EXP_W + 2;          // signed headroom for normalise
  localparam int unsigned LZW = $clog2(MW + 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Handshake chain: each stage loads when its downstream is empty or advancing
  logic s1_v, s2_v;
  logic s1_ld, s2_ld, s3_ld;
  assign s3_ld    = !out_valid || out_ready;
  assign s2_ld    = !s2_v || s3_ld;
  assign s1_ld    = !s1_v || (s2_v ? s3_ld : 1'b1);
  assign in_ready = s1_ld;

  // Unpack / swap / align
  logic               sa, sb, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, a_snan, b_snan;
  logic [EXP_W-1:0]   ea, eb, el, es, d;
  logic [MAN_W-1:0]   fa, fb, fl, fs;
  logic               a_big, sl, hl, hs, far;
  logic [MW-1:0]      ext_s, shifted, ml_al, ms_al;
  logic               dropped;
  logic               spec_c;
  logic [W-1:0]       spec_res_c;
  logic [3:0]         spec_flags_c;

  assign sa     = in_a[W-1];
  assign sb     = in_b[W-1] ^ in_sub;
  assign ea     = in_a[W-2:MAN_W];
  assign eb     = in_b[W-2:MAN_W];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign fa     = a_zero ? '0 : in_a[MAN_W-1:0];
  assign fb     = b_zero ? '0 : in_b[MAN_W-1:0];
  assign a_nan  = (&ea) && (fa != '0);
  assign b_nan  = (&eb) && (fb != '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_snan = a_nan && !fa[MAN_W-1];
  assign b_snan = b_nan && !fb[MAN_W-1];

  assign a_big   = {ea, fa} >= {eb, fb};
  assign el      = a_big ? ea : eb;
  assign es      = a_big ? eb : ea;
  assign fl      = a_big ? fa : fb;
  assign fs      = a_big ? fb : fa;
  assign sl      = a_big ? sa : sb;
  assign hl      = a_big ? !a_zero : !b_zero;
  assign hs      = a_big ? !b_zero : !a_zero;
  assign d       = el - es;
  assign far     = 32'(d) >= 32'(MAN_W + 3);
  assign ext_s   = {hs, fs, 3'b000};
  assign shifted = ext_s >> d;
  assign dropped = |(ext_s & ((MW'(1) << d) - MW'(1)));
  assign ml_al   = {hl, fl, 3'b000};
  assign ms_al   = far ? {{(MW-1){1'b0}}, |ext_s} : {shifted[MW-1:1], shifted[0] | dropped};

  // Special operands override the arithmetic result
  always_comb begin
    spec_c       = 1'b0;
    spec_res_c   = '0;
    spec_flags_c = '0;
    if (a_nan || b_nan) begin
      spec_c       = 1'b1;
      spec_res_c   = QNAN;
      spec_flags_c = {a_snan || b_snan, 3'b000};
    end else if (a_inf && b_inf && (sa != sb)) begin
      spec_c       = 1'b1;
      spec_res_c   = QNAN;
      spec_flags_c = 4'b1000;
    end else if (a_inf) begin
      spec_c     = 1'b1;
      spec_res_c = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      spec_c     = 1'b1;
      spec_res_c = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  logic [MW-1:0]    s1_ml, s1_ms;
  logic [EXP_W-1:0] s1_exp;
  logic             s1_sign, s1_esub, s1_zsign, s1_spec;
  logic [W-1:0]     s1_spec_res;
  logic [3:0]       s1_spec_flags;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0; s1_ml <= '0; s1_ms <= '0; s1_exp <= '0; s1_sign <= 1'b0;
      s1_esub <= 1'b0; s1_zsign <= 1'b0; s1_spec <= 1'b0; s1_spec_res <= '0;
      s1_spec_flags <= '0; s1_tag <= '0;
    end else begin
      if (s1_ld) s1_v <= in_valid;
      if (s1_ld && in_valid) begin
        s1_ml         <= ml_al;
        s1_ms         <= ms_al;
        s1_exp        <= el;
        s1_sign       <= sl;
        s1_esub       <= sa ^ sb;
        s1_zsign      <= a_zero && b_zero && sa && sb;
        s1_spec       <= spec_c;
        s1_spec_res   <= spec_res_c;
        s1_spec_flags <= spec_flags_c;
        s1_tag        <= in_tag;
      end
    end
  end

  // Add / subtract magnitudes; larger minus smaller never goes negative
  logic [SW-1:0]    s2_sum;
  logic [EXP_W-1:0] s2_exp;
  logic             s2_sign, s2_zsign, s2_spec;
  logic [W-1:0]     s2_spec_res;
  logic [3:0]       s2_spec_flags;
  logic [TAG_W-1:0] s2_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v <= 1'b0; s2_sum <= '0; s2_exp <= '0; s2_sign <= 1'b0; s2_zsign <= 1'b0;
      s2_spec <= 1'b0; s2_spec_res <= '0; s2_spec_flags <= '0; s2_tag <= '0;
    end else begin
      if (s2_ld) s2_v <= s1_v;
      if (s2_ld && s1_v) begin
        s2_sum        <= s1_esub ? ({1'b0, s1_ml} - {1'b0, s1_ms})
                                 : ({1'b0, s1_ml} + {1'b0, s1_ms});
        s2_exp        <= s1_exp;
        s2_sign       <= s1_sign;
        s2_zsign      <= s1_zsign;
        s2_spec       <= s1_spec;
        s2_spec_res   <= s1_spec_res;
        s2_spec_flags <= s1_spec_flags;
        s2_tag        <= s1_tag;
      end
    end
  end

  function automatic logic [LZW-1:0] lzc_f(input logic [MW-1:0] v);
    lzc_f = LZW'(MW);
    for (int i = 0; i < int'(MW); i++)
      if (v[i]) lzc_f = LZW'(int'(MW) - 1 - i);
  endfunction

  // Normalise / round / pack
  logic [LZW-1:0]   lz;
  logic [MW-1:0]    norm;
  logic [EW-1:0]    exp_n, exp_r;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] frac_r;
  logic             inc, nx, uf, of;
  logic [W-1:0]     res_c;
  logic [3:0]       flags_c;

  always_comb begin
    lz = lzc_f(s2_sum[MW-1:0]);
    if (s2_sum[SW-1]) begin
      norm  = {s2_sum[SW-1:2], |s2_sum[1:0]};
      exp_n = EW'(s2_exp) + EW'(1);
    end else begin
      norm  = s2_sum[MW-1:0] << lz;
      exp_n = EW'(s2_exp) - EW'(lz);
    end
    inc    = norm[2] && (norm[1] || norm[0] || norm[3]);
    nx     = |norm[2:0];
    mant_r = {1'b0, norm[MW-1:3]} + (MAN_W+2)'(inc);
    exp_r  = mant_r[MAN_W+1] ? exp_n + EW'(1) : exp_n;
    frac_r = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    uf     = exp_n[EW-1] || (exp_n == '0);
    of     = exp_r >= {2'b00, {EXP_W{1'b1}}};

    res_c   = {s2_sign, exp_r[EXP_W-1:0], frac_r};
    flags_c = {3'b000, nx};
    if (s2_spec) begin
      res_c   = s2_spec_res;
      flags_c = s2_spec_flags;
    end else if (s2_sum == '0) begin
      res_c   = {s2_zsign, {(W-1){1'b0}}};
      flags_c = '0;
    end else if (uf) begin
      res_c   = {s2_sign, {(W-1){1'b0}}};
      flags_c = 4'b0011;
    end else if (of) begin
      res_c   = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_c = 4'b0101;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0; out_result <= '0; out_tag <= '0; out_flags <= '0;
    end else begin
      if (s3_ld) out_valid <= s2_v;
      if (s3_ld && s2_v) begin
        out_result <= res_c;
        out_tag    <= s2_tag;
        out_flags  <= flags_c;
      end
    end
  end

endmodule
